// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response channels and SPI pins of the SPI master controller.
// cmd and rsp are valid/ready channels: a beat moves on the rising clk_sys edge where valid and ready are both 1; valid and payload hold until then.
interface spi_master_ctrl_if #(
  parameter int NUM_BITS = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [NUM_BITS-1:0] cmd_data;
  logic                cmd_last;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [NUM_BITS-1:0] rsp_data;
  logic                spi_clk;
  logic                spi_mosi;
  logic                spi_miso;
  logic                spi_cs_n;
  logic                busy;

  // Host / environment side: issues commands, consumes responses, drives miso.
  modport master (
    output cmd_valid, cmd_data, cmd_last, rsp_ready, spi_miso,
    input  cmd_ready, rsp_valid, rsp_data, spi_clk, spi_mosi, spi_cs_n, busy
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_data, cmd_last, rsp_ready, spi_miso,
    output cmd_ready, rsp_valid, rsp_data, spi_clk, spi_mosi, spi_cs_n, busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: shifts one NUM_BITS word per command MSB first, returns the sampled word,
// and optionally keeps chip select asserted across commands to build multi-word frames.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int NUM_BITS = 8
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  spi_master_ctrl_if.slave bus,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] PH_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_ALL = BW'(NUM_BITS);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOW      = 3'd1,
    HIGH     = 3'd2,
    HOLD     = 3'd3,
    WAIT_RSP = 3'd4
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       ph_cnt_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [NUM_BITS-1:0] tx_q;
  logic [NUM_BITS-1:0] rx_q;
  logic                last_q;
  logic                spi_clk_q;
  logic                mosi_q;
  logic                cs_n_q;
  logic                rsp_valid_q;
  logic [NUM_BITS-1:0] rsp_data_q;

  logic [NUM_BITS-1:0] tx_shift_d;
  logic [NUM_BITS-1:0] rx_shift_d;
  logic                phase_end;
  logic                cmd_ready;

  assign phase_end  = (ph_cnt_q == PH_LAST);
  assign tx_shift_d = tx_q << 1;
  assign cmd_ready  = (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    rx_shift_d    = rx_q << 1;
    rx_shift_d[0] = bus.spi_miso;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q     <= IDLE;
      ph_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b0;
      spi_clk_q   <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An open frame parks here with cs_n low, clock low and mosi on its last bit.
          if (bus.cmd_valid && cmd_ready) begin
            tx_q      <= bus.cmd_data;
            last_q    <= bus.cmd_last;
            mosi_q    <= bus.cmd_data[NUM_BITS-1];
            cs_n_q    <= 1'b0;
            bit_cnt_q <= BITS_ALL;
            ph_cnt_q  <= '0;
            rx_q      <= '0;
            state_q   <= LOW;
          end
        end

        LOW: begin
          if (phase_end) begin
            ph_cnt_q  <= '0;
            spi_clk_q <= 1'b1;
            rx_q      <= rx_shift_d;
            state_q   <= HIGH;
          end else begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
          end
        end

        HIGH: begin
          if (phase_end) begin
            ph_cnt_q  <= '0;
            spi_clk_q <= 1'b0;
            bit_cnt_q <= bit_cnt_q - 1'b1;
            if (bit_cnt_q == BIT_ONE) begin
              if (last_q) begin
                state_q <= HOLD;
              end else begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rx_q;
                state_q     <= WAIT_RSP;
              end
            end else begin
              tx_q    <= tx_shift_d;
              mosi_q  <= tx_shift_d[NUM_BITS-1];
              state_q <= LOW;
            end
          end else begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
          end
        end

        HOLD: begin
          // Gives the slave one extra half-period of select after the final falling edge.
          if (phase_end) begin
            ph_cnt_q    <= '0;
            cs_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_q;
            state_q     <= WAIT_RSP;
          end else begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
          end
        end

        WAIT_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.spi_clk   = spi_clk_q;
  assign bus.spi_mosi  = mosi_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a CLK_DIV=2 instance for framing, hold and reset cases,
// and a CLK_DIV=1 instance for the fastest clock ratio; responses are scoreboarded.
module tb_spi_master_ctrl;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl_if #(.NUM_BITS(NB)) if0 ();
  spi_master_ctrl_if #(.NUM_BITS(NB)) if1 ();
  logic [2:0] dbg0, dbg1;
  logic       tie_one;

  assign if0.spi_miso = tie_one ? 1'b1 : if0.spi_mosi;
  assign if1.spi_miso = if1.spi_mosi;

  spi_master_ctrl #(.CLK_DIV(2), .NUM_BITS(NB)) dut0 (
    .clk_sys(clk), .rst_sys(rst), .bus(if0.slave), .dbg_state_o(dbg0)
  );
  spi_master_ctrl #(.CLK_DIV(1), .NUM_BITS(NB)) dut1 (
    .clk_sys(clk), .rst_sys(rst), .bus(if1.slave), .dbg_state_o(dbg1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [NB-1:0] exp0_q[$];
  logic [NB-1:0] exp1_q[$];
  int   rise_cyc[$];
  logic rise_mosi[$];
  logic clk_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Main thread acts at negedge+2; watcher samples at +1, scoreboard monitor at +3.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  always begin
    @(negedge clk);
    #1;
    if (if0.spi_clk && !clk_prev) begin
      rise_cyc.push_back(cyc);
      rise_mosi.push_back(if0.spi_mosi);
    end
    clk_prev = if0.spi_clk;
  end

  always begin
    @(negedge clk);
    #3;
    if (!rst && if0.rsp_valid && if0.rsp_ready) begin
      check("sb0_pending", exp0_q.size() > 0, 1);
      if (exp0_q.size() > 0) check("sb0_rsp_data", if0.rsp_data, exp0_q.pop_front());
    end
    if (!rst && if1.rsp_valid && if1.rsp_ready) begin
      check("sb1_pending", exp1_q.size() > 0, 1);
      if (exp1_q.size() > 0) check("sb1_rsp_data", if1.rsp_data, exp1_q.pop_front());
    end
  end

  task automatic issue0(input logic [NB-1:0] d, input logic l, output int t);
    int w = 0;
    if0.cmd_valid = 1'b1;
    if0.cmd_data  = d;
    if0.cmd_last  = l;
    t = -1;
    while (!if0.cmd_ready && w < 100) begin
      tick();
      w++;
    end
    check("cmd_accept", if0.cmd_ready, 1);
    t = cyc;
    tick();
    if0.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp0(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      if (if0.rsp_valid) begin
        c = cyc;
        break;
      end
      tick();
    end
    if (c < 0) check("rsp0_arrival", if0.rsp_valid, 1);
  endtask

  task automatic check_rises(input string tag, input int t, input logic [NB-1:0] exp_bits);
    logic [NB-1:0] bits = '0;
    int bad_gap = 0;
    for (int i = 0; i < rise_cyc.size(); i++) begin
      bits = {bits[NB-2:0], rise_mosi[i]};
      if (i > 0 && rise_cyc[i] - rise_cyc[i-1] != 4) bad_gap++;
    end
    check({tag, "_rise_count"}, rise_cyc.size(), NB);
    check({tag, "_mosi_at_rises"}, bits, exp_bits);
    check({tag, "_rise_spacing"}, bad_gap, 0);
    if (rise_cyc.size() > 0) check({tag, "_first_rise"}, rise_cyc[0] - t, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, c, cdone, bad, w;
    rst = 1'b1;
    tie_one = 1'b0;
    if0.cmd_valid = 1'b0; if0.cmd_data = '0; if0.cmd_last = 1'b0; if0.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_data = '0; if1.cmd_last = 1'b0; if1.rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready", if0.cmd_ready, 1);
    check("rst_busy", if0.busy, 0);
    check("rst_cs_n", if0.spi_cs_n, 1);
    check("rst_spi_clk", if0.spi_clk, 0);
    check("rst_mosi", if0.spi_mosi, 0);
    check("rst_rsp_valid", if0.rsp_valid, 0);
    check("rst_rsp_data", if0.rsp_data, 0);

    // 0xA5, last=1, loopback
    if0.rsp_ready = 1'b1;
    exp0_q.push_back(8'hA5);
    rise_cyc.delete(); rise_mosi.delete();
    issue0(8'hA5, 1'b1, t);
    check("a5_cs_n_t1", if0.spi_cs_n, 0);
    check("a5_mosi_t1", if0.spi_mosi, 1);
    check("a5_busy_t1", if0.busy, 1);
    check("a5_cmd_ready_t1", if0.cmd_ready, 0);
    wait_rsp0(c);
    check("a5_rsp_cycle", c - t, 35);
    check("a5_cs_n_at_rsp", if0.spi_cs_n, 1);
    check_rises("a5", t, 8'hA5);
    tick();
    check("a5_idle_busy", if0.busy, 0);

    // Open frame: 0x3C last=0 then 0xC3 last=1, miso tied high
    tie_one = 1'b1;
    exp0_q.push_back(8'hFF);
    issue0(8'h3C, 1'b0, t);
    wait_rsp0(c);
    check("3c_rsp_cycle", c - t, 33);
    check("3c_cs_n_at_rsp", if0.spi_cs_n, 0);
    tick();
    check("open_cs_n", if0.spi_cs_n, 0);
    check("open_spi_clk", if0.spi_clk, 0);
    check("open_mosi", if0.spi_mosi, 0);
    check("open_busy", if0.busy, 0);
    exp0_q.push_back(8'hFF);
    issue0(8'hC3, 1'b1, t);
    check("c3_cs_n_t1", if0.spi_cs_n, 0);
    check("c3_mosi_t1", if0.spi_mosi, 1);
    wait_rsp0(c);
    check("c3_rsp_cycle", c - t, 35);
    check("c3_cs_n_at_rsp", if0.spi_cs_n, 1);
    tick();

    // Response back-pressure, then same-cycle consume + new command
    tie_one = 1'b0;
    if0.rsp_ready = 1'b0;
    exp0_q.push_back(8'h5A);
    issue0(8'h5A, 1'b1, t);
    wait_rsp0(c);
    check("5a_rsp_cycle", c - t, 35);
    if0.cmd_valid = 1'b1; if0.cmd_data = 8'h11; if0.cmd_last = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (if0.cmd_ready !== 1'b0 || if0.rsp_valid !== 1'b1 || if0.rsp_data !== 8'h5A || dbg0 !== 3'd4) bad++;
      tick();
    end
    check("hold_window_stable", bad, 0);
    if0.rsp_ready = 1'b1;
    cdone = cyc;
    exp0_q.push_back(8'h11);
    issue0(8'h11, 1'b1, t2);
    check("b2b_accept_cycle", t2 - cdone, 1);
    wait_rsp0(c);
    check("11_rsp_cycle", c - t2, 35);
    tick();

    // Reset after the third rising spi_clk edge
    rise_cyc.delete(); rise_mosi.delete();
    issue0(8'hF0, 1'b1, t);
    w = 0;
    while (rise_cyc.size() < 3 && w < 100) begin
      tick();
      w++;
    end
    check("rst_mid_third_rise", rise_cyc.size() >= 3, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_cs_n", if0.spi_cs_n, 1);
    check("rst_mid_spi_clk", if0.spi_clk, 0);
    check("rst_mid_busy", if0.busy, 0);
    check("rst_mid_mosi", if0.spi_mosi, 0);
    check("rst_mid_state", dbg0, 0);
    tick();
    rst = 1'b0;
    tick();
    exp0_q.push_back(8'h81);
    rise_cyc.delete(); rise_mosi.delete();
    issue0(8'h81, 1'b1, t);
    wait_rsp0(c);
    check("81_rsp_cycle", c - t, 35);
    check_rises("81", t, 8'h81);
    tick();

    // CLK_DIV=1 instance: 0x96, last=1, loopback
    exp1_q.push_back(8'h96);
    if1.cmd_valid = 1'b1; if1.cmd_data = 8'h96; if1.cmd_last = 1'b1;
    w = 0;
    while (!if1.cmd_ready && w < 100) begin
      tick();
      w++;
    end
    check("d1_cmd_accept", if1.cmd_ready, 1);
    t = cyc;
    tick();
    if1.cmd_valid = 1'b0;
    check("d1_clk_t1", if1.spi_clk, 0);
    tick();
    check("d1_clk_t2", if1.spi_clk, 1);
    tick();
    check("d1_clk_t3", if1.spi_clk, 0);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      if (if1.rsp_valid) begin
        c = cyc;
        break;
      end
      tick();
    end
    check("d1_rsp_cycle", c - t, 18);
    check("d1_cs_n_at_rsp", if1.spi_cs_n, 1);

    repeat (4) tick();
    check("sb0_drained", exp0_q.size(), 0);
    check("sb1_drained", exp1_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2, spi_clk half-period in clk_sys cycles; legal range 1..255.
REQ-002 Parameter NUM_BITS, default 8, bits per byte transfer; legal range 1..16.
REQ-003 Port clk_sys  input  1  system clock; all logic is rising-edge clk_sys.
REQ-004 Port rst_sys  input  1  asynchronous active-high reset.
REQ-005 Port cmd_valid  input  1  host presents a byte to transmit.
REQ-006 Port cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 Port cmd_data  input  NUM_BITS  byte to shift out, MSB first.
REQ-008 Port cmd_last  input  1  1 = release spi_cs_n after this byte; 0 = keep frame open.
REQ-009 Port rsp_valid  output  1  received byte available.
REQ-010 Port rsp_ready  input  1  host consumes the response.
REQ-011 Port rsp_data  output  NUM_BITS  byte sampled from spi_miso.
REQ-012 Port spi_clk  output  1  SPI clock, mode 0 (idle low).
REQ-013 Port spi_mosi  output  1  serial data to the spi_slave.
REQ-014 Port spi_miso  input  1  serial data from the spi_slave, treated as synchronous to clk_sys.
REQ-015 Port spi_cs_n  output  1  active-low frame select.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, LOW (spi_clk=0 phase), HIGH (spi_clk=1 phase), HOLD (post-byte CS hold), WAIT_RSP.
REQ-018 cmd_ready is 1 only in IDLE with rsp_valid=0.
REQ-019 On cmd_valid&cmd_ready at cycle T: latch cmd_data and cmd_last, enter LOW at T+1.
REQ-020 At T+1: spi_cs_n=0 and spi_mosi=cmd_data[NUM_BITS-1].
REQ-021 Phase counter counts CLK_DIV cycles per phase, so each LOW and each HIGH phase lasts exactly CLK_DIV cycles.
REQ-022 LOW->HIGH transition: spi_clk rises, and spi_miso is sampled into the receive shift register LSB on that same clk_sys edge.
REQ-023 HIGH->LOW transition (not last bit): spi_clk falls, and spi_mosi advances to the next lower bit on that same edge.
REQ-024 Bit counter decrements per HIGH phase; after the NUM_BITS-th HIGH phase spi_clk falls at cycle T+1+2*NUM_BITS*CLK_DIV.
REQ-025 At that edge, if cmd_last=1: enter HOLD for CLK_DIV cycles, then set spi_cs_n=1 and rsp_valid=1 together, entering WAIT_RSP.
REQ-026 At that edge, if cmd_last=0: set rsp_valid=1 immediately, keep spi_cs_n=0, and enter WAIT_RSP.
REQ-027 rsp_data and rsp_valid hold stable until rsp_valid&rsp_ready; state then returns to IDLE.
REQ-028 Open frame (cs_n=0) in IDLE: spi_clk stays 0 and spi_mosi holds its last bit until the next command.
REQ-029 New cmd_valid is ignored while cmd_ready=0; no buffering beyond one command.
REQ-030 rsp_ready asserted without rsp_valid has no effect.

Reset
REQ-031 rst_sys asserted at any time, including mid-byte, immediately forces state=IDLE, spi_clk=0, spi_mosi=0, spi_cs_n=1, rsp_valid=0, rsp_data=0, busy=0, and all counters to 0.
REQ-032 After rst_sys deasserts, the first accepted command starts a fresh frame; no partial-byte state survives.

Verification
REQ-033 CLK_DIV=2, cmd_data=0xA5, cmd_last=1, miso looped to mosi -> 8 spi_clk rising edges, each 4 cycles apart; mosi=1,0,1,0,0,1,0,1; rsp_data=0xA5; cs_n rises and rsp_valid=1 at T+35.
REQ-034 Two commands 0x3C (last=0) then 0xC3 (last=1), miso tied 1 -> cs_n stays 0 between bytes; both rsp_data=0xFF; cs_n=1 only after the second byte.
REQ-035 rsp_ready held 0 for 20 cycles after rsp_valid -> cmd_ready=0 and rsp_data stable throughout; cmd_valid during this window is not accepted.
REQ-036 rst_sys pulsed after the 3rd spi_clk rise of a byte -> same-cycle spi_cs_n=1, spi_clk=0, busy=0; a following command 0x81 completes normally.
REQ-037 CLK_DIV=1, NUM_BITS=8 -> spi_clk toggles every cycle; rsp_valid at T+1+16+1=T+18 with cmd_last=1.
REQ-038 cmd_valid and rsp_ready asserted in the same cycle as response completion -> response consumed that cycle; command accepted no earlier than the next cycle.
